matrix_drain: RTL and testbench

Streams the VECTOR_SIZE×VECTOR_SIZE result matrix out of the Z BRAM after the multiply engine has finished writing it. It issues Z read addresses in row-major order, absorbs the one-cycle BRAM read latency, and presents each word on a valid/ready output stream. It sits between the Z BRAM read port and the host/DMA sink, and is started by the top-level controller once the multiply engine reports done.

---
 rtl/matrix_drain.sv | 250 +++++++++++++++++++++++++
 tb/tb_matrix_drain.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_drain.sv
// -----------------------------------------------------------------------------
// matrix_drain
//
// Streams the VECTOR_SIZE x VECTOR_SIZE result matrix out of the Z BRAM once
// the multiply engine has finished writing it. Read addresses are issued in
// row-major order, the one-cycle BRAM read latency is absorbed by a 2-entry
// output FIFO, and every word is presented on a valid/ready stream.
//
// Optional feature macro: ZDRAIN_CSUM_EN
//   defined   : csum is a DATA_WIDTH wrap-around sum of every word handed to
//               the sink during the current pass. It is cleared when a start
//               is accepted and holds after the done pulse.
//   undefined : csum is tied to zero and no accumulator exists.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   start      in   begin one drain pass (sampled only while idle)
//   busy       out  high from the cycle after start is accepted until done
//   done       out  one-cycle pulse after the final word's handshake
//   z_addr     out  Z BRAM read address (combinational from the read index)
//   z_dout     in   Z BRAM read data, valid one cycle after z_addr
//   out_data   out  stream payload (FIFO head)
//   out_valid  out  stream payload valid
//   out_ready  in   sink ready; a word moves when out_valid && out_ready
//   out_last   out  high while the head word is word N-1
//   csum       out  pass checksum (see macro above)
// -----------------------------------------------------------------------------
module matrix_drain #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int VECTOR_SIZE = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] z_addr,
  input  logic [DATA_WIDTH-1:0] z_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] csum
);

  localparam int N  = VECTOR_SIZE * VECTOR_SIZE;
  // One extra bit so the read index can count up to N itself.
  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [IW-1:0] N_IDX    = IW'(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         rd_idx_q, rd_idx_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // FIFO: the head slot drives the stream outputs directly so they are
  // registered; the tail slot only fills while the sink is stalled.
  logic                  head_valid_q, head_valid_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic                  head_last_q, head_last_d;
  logic                  tail_valid_q, tail_valid_d;
  logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
  logic                  tail_last_q, tail_last_d;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  credit_ok;
  logic [1:0]            used;

  assign push = inflight_q;
  assign pop  = head_valid_q && out_ready;

  // Slots already spoken for: buffered words plus the read still in flight.
  // A pop this cycle frees one slot, so the threshold rises by one.
  assign used      = {1'b0, head_valid_q} + {1'b0, tail_valid_q} + {1'b0, inflight_q};
  assign credit_ok = pop ? (used < 2'd3) : (used < 2'd2);

  always_comb begin
    state_d         = state_q;
    rd_idx_d        = rd_idx_q;
    inflight_d      = 1'b0;
    inflight_last_d = inflight_last_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    issue           = 1'b0;

    head_valid_d    = head_valid_q;
    head_data_d     = head_data_q;
    head_last_d     = head_last_q;
    tail_valid_d    = tail_valid_q;
    tail_data_d     = tail_data_q;
    tail_last_d     = tail_last_q;

    // FIFO movement. The tail only ever feeds the head, and a push lands in
    // the first slot that will be free after this cycle's pop.
    if (state_q != IDLE) begin
      if (pop) begin
        if (tail_valid_q) begin
          head_valid_d = 1'b1;
          head_data_d  = tail_data_q;
          head_last_d  = tail_last_q;
          tail_valid_d = push;
          if (push) begin
            tail_data_d = z_dout;
            tail_last_d = inflight_last_q;
          end
        end else begin
          head_valid_d = push;
          if (push) begin
            head_data_d = z_dout;
            head_last_d = inflight_last_q;
          end
        end
      end else if (push) begin
        if (!head_valid_q) begin
          head_valid_d = 1'b1;
          head_data_d  = z_dout;
          head_last_d  = inflight_last_q;
        end else begin
          tail_valid_d = 1'b1;
          tail_data_d  = z_dout;
          tail_last_d  = inflight_last_q;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d         = RUN;
          rd_idx_d        = '0;
          inflight_last_d = 1'b0;
          head_valid_d    = 1'b0;
          tail_valid_d    = 1'b0;
          busy_d          = 1'b1;
        end
      end

      RUN: begin
        issue = (rd_idx_q < N_IDX) && credit_ok;
        if (issue) begin
          rd_idx_d        = rd_idx_q + ONE_IDX;
          inflight_d      = 1'b1;
          inflight_last_d = (rd_idx_q == LAST_IDX);
          if (rd_idx_q == LAST_IDX) begin
            state_d = FLUSH;
          end
        end
      end

      FLUSH: begin
        // Only the final word carries the last tag, so popping it means
        // the FIFO is draining empty and nothing is left in flight.
        if (pop && head_last_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      rd_idx_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      head_valid_q    <= 1'b0;
      head_data_q     <= '0;
      head_last_q     <= 1'b0;
      tail_valid_q    <= 1'b0;
      tail_data_q     <= '0;
      tail_last_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_idx_q        <= rd_idx_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      head_valid_q    <= head_valid_d;
      head_data_q     <= head_data_d;
      head_last_q     <= head_last_d;
      tail_valid_q    <= tail_valid_d;
      tail_data_q     <= tail_data_d;
      tail_last_q     <= tail_last_d;
    end
  end

  // The read index is only meaningful while reads are being issued.
  always_comb begin
    z_addr = '0;
    if (state_q == RUN) begin
      z_addr = rd_idx_q[ADDR_WIDTH-1:0];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_data  = head_data_q;
  assign out_valid = head_valid_q;
  assign out_last  = head_last_q;

`ifdef ZDRAIN_CSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && start) begin
      csum_d = '0;
    end else if (pop) begin
      csum_d = csum_q + head_data_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_matrix_drain.sv
// -----------------------------------------------------------------------------
// tb_matrix_drain
//
// Drives matrix_drain against a behavioural Z BRAM. A negedge monitor keeps a
// word-level model of the pass (which word the sink must see next, whether a
// pass is open, when done is due, the running checksum) and compares the DUT
// against it every cycle. Directed passes pin latency, stall and checksum
// values with hand-computed literals; random passes vary data and out_ready.
// -----------------------------------------------------------------------------
module tb_matrix_drain;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int VS = 8;
  localparam int N  = VS * VS;

  logic          clock     = 1'b0;
  logic          reset     = 1'b1;
  logic          start     = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic          out_last;
  logic [AW-1:0] z_addr;
  logic [DW-1:0] z_dout = '0;
  logic [DW-1:0] out_data;
  logic [DW-1:0] csum;

  logic [DW-1:0] zmem [N];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  bit            m_busy      = 1'b0;
  bit            m_done_next = 1'b0;
  bit            prev_stall  = 1'b0;
  bit            first_seen  = 1'b0;
  int            m_idx       = 0;
  int            pass_words  = 0;
  int            done_cnt    = 0;
  int            e0          = 0;
  int            first_edge  = 0;
  int            done_edge   = 0;
  logic [DW-1:0] m_csum      = '0;
  logic [DW-1:0] prev_data   = '0;
  logic          prev_last   = 1'b0;

  matrix_drain #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .VECTOR_SIZE(VS)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .z_addr   (z_addr),
    .z_dout   (z_dout),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .csum     (csum)
  );

  always #5 clock = ~clock;

  // Synchronous-read BRAM: data appears one cycle after the address.
  always @(posedge clock) begin
    cyc    <= cyc + 1;
    z_dout <= zmem[z_addr];
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic readyFor(input int mode, input int k);
    case (mode)
      1:       return (k % 4 == 0) || (k % 4 == 3);
      2:       return $urandom_range(0, 3) != 0;
      3:       return k >= 20;
      default: return 1'b1;
    endcase
  endfunction

  // Word-level reference: the sink must receive zmem[0..N-1] in order, done
  // pulses in the cycle after word N-1 moves, start is honoured only when no
  // pass is open, and a stalled word may not change or vanish.
  always @(negedge clock) begin
    bit            was_busy;
    logic [DW-1:0] exp_csum;
    if (reset) begin
      checkOutput("rst_busy",      DW'(busy),      '0);
      checkOutput("rst_done",      DW'(done),      '0);
      checkOutput("rst_out_valid", DW'(out_valid), '0);
      checkOutput("rst_out_last",  DW'(out_last),  '0);
      checkOutput("rst_out_data",  out_data,       '0);
      checkOutput("rst_z_addr",    DW'(z_addr),    '0);
      checkOutput("rst_csum",      csum,           '0);
      m_busy      = 1'b0;
      m_done_next = 1'b0;
      m_idx       = 0;
      m_csum      = '0;
      prev_stall  = 1'b0;
    end else begin
      was_busy = m_busy;
      checkOutput("busy", DW'(busy), DW'(m_busy));
      checkOutput("done", DW'(done), DW'(m_done_next));
      if (done) begin
        done_cnt++;
        done_edge = cyc;
      end
      m_done_next = 1'b0;

      if (!was_busy) begin
        checkOutput("idle_out_valid", DW'(out_valid), '0);
        checkOutput("idle_z_addr",    DW'(z_addr),    '0);
      end

      if (prev_stall) begin
        checkOutput("stall_out_valid", DW'(out_valid), 32'd1);
        checkOutput("stall_out_data",  out_data,       prev_data);
        checkOutput("stall_out_last",  DW'(out_last),  DW'(prev_last));
      end

`ifdef ZDRAIN_CSUM_EN
      exp_csum = m_csum;
`else
      exp_csum = '0;
`endif
      checkOutput("csum", csum, exp_csum);

      if (out_valid) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          first_edge = cyc;
        end
        if (m_idx < N) begin
          checkOutput("out_data", out_data,      zmem[m_idx]);
          checkOutput("out_last", DW'(out_last), DW'(m_idx == N - 1));
          if (out_ready) begin
            m_csum = m_csum + zmem[m_idx];
            pass_words++;
            if (m_idx == N - 1) begin
              m_done_next = 1'b1;
              m_busy      = 1'b0;
            end
            m_idx++;
          end
        end else begin
          checkOutput("word_beyond_n", DW'(m_idx), DW'(N - 1));
        end
      end

      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;

      if (!was_busy && start) begin
        m_busy     = 1'b1;
        m_idx      = 0;
        m_csum     = '0;
        pass_words = 0;
        first_seen = 1'b0;
        e0         = cyc + 1;
      end
    end
  end

  // mode 0: ready high; 1: ready 1,0,0,1 pattern; 2: random ready;
  // 3: ready low for 20 cycles after start; 4: stray start pulses at words
  // 10 and 40; 5: reset at word 30 (pass abandoned).
  task automatic applyStimulus(input int mode);
    int base;
    bit f10;
    bit f40;
    base = done_cnt;
    f10  = 1'b0;
    f40  = 1'b0;
    @(posedge clock); #1;
    start     = 1'b1;
    out_ready = readyFor(mode, 0);
    for (int k = 1; k <= 600 && done_cnt == base; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (mode == 3 && k == 20) begin
        checkOutput("stall_z_addr_held", DW'(z_addr),    32'd2);
        checkOutput("stall_valid_held",  DW'(out_valid), 32'd1);
        checkOutput("stall_head_word0",  out_data,       32'd0);
      end
      out_ready = readyFor(mode, k);
      if (mode == 4) begin
        if (!f10 && m_idx >= 10) begin
          start = 1'b1;
          f10   = 1'b1;
        end else if (!f40 && m_idx >= 40) begin
          start = 1'b1;
          f40   = 1'b1;
        end
      end
      if (mode == 5 && m_idx >= 30) begin
        reset = 1'b1;
        #1;
        checkOutput("midpass_rst_valid", DW'(out_valid), '0);
        checkOutput("midpass_rst_busy",  DW'(busy),      '0);
        checkOutput("midpass_rst_data",  out_data,       '0);
        @(posedge clock); #1;
        reset = 1'b0;
        return;
      end
    end
    if (done_cnt == base) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL done_timeout: mode %0d got no done within 600 cycles", mode);
    end
    repeat (4) begin
      @(posedge clock); #1;
      start     = 1'b0;
      out_ready = 1'b1;
    end
    checkOutput("done_pulses_per_pass", DW'(done_cnt - base), 32'd1);
    checkOutput("words_per_pass",       DW'(pass_words),      DW'(N));
  endtask

  initial begin
    for (int a = 0; a < N; a++) zmem[a] = DW'(a);
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("init_busy",      DW'(busy),      '0);
    checkOutput("init_out_valid", DW'(out_valid), '0);
    checkOutput("init_z_addr",    DW'(z_addr),    '0);
    reset = 1'b0;

    $display("[TB] pass: ready held high, Z[a]=a");
    applyStimulus(0);
    checkOutput("first_valid_latency", DW'(first_edge - e0), 32'd2);
    checkOutput("done_latency",        DW'(done_edge - e0),  32'd66);
`ifdef ZDRAIN_CSUM_EN
    checkOutput("csum_ramp", csum, 32'd2016);
`else
    checkOutput("csum_ramp", csum, 32'd0);
`endif

    $display("[TB] pass: ready pattern 1,0,0,1");
    applyStimulus(1);
    $display("[TB] pass: ready low for 20 cycles");
    applyStimulus(3);
    $display("[TB] pass: stray start pulses");
    applyStimulus(4);
    $display("[TB] pass: reset at word 30, then fresh pass");
    applyStimulus(5);
    applyStimulus(0);

    for (int a = 0; a < N; a++) zmem[a] = 32'hFFFF_FFFF;
    $display("[TB] pass: all-ones matrix");
    applyStimulus(0);
`ifdef ZDRAIN_CSUM_EN
    checkOutput("csum_ones", csum, 32'hFFFF_FFC0);
`else
    checkOutput("csum_ones", csum, 32'd0);
`endif

    repeat (4) begin
      for (int a = 0; a < N; a++) zmem[a] = $urandom;
      $display("[TB] pass: random data, random ready");
      applyStimulus(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
